// File: rtl/inst_fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Holds the fetch FSM state enum, the bus widths and the NOP word.
package inst_fetch_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    localparam logic [DATA_W-1:0] INST_NOP = '0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_ADDR,
        S_WAIT_DATA,
        S_HOLD,
        S_CANCEL
    } fetch_state_t;

endpackage

// File: rtl/inst_fetch_if.sv
// Instruction bus between the fetch stage (master) and the memory side (slave).
// The master issues one word request at a time; the slave acknowledges the address first, then returns the data.
interface inst_fetch_if;
    import inst_fetch_pkg::*;

    logic              inst_req;
    logic [ADDR_W-1:0] inst_addr;
    logic              inst_addr_ok;
    logic              inst_data_ok;
    logic [DATA_W-1:0] inst_rdata;

    modport master (
        output inst_req, inst_addr,
        input  inst_addr_ok, inst_data_ok, inst_rdata
    );

    modport slave (
        input  inst_req, inst_addr,
        output inst_addr_ok, inst_data_ok, inst_rdata
    );

endinterface

// File: rtl/inst_fetch.sv
// Instruction fetch stage: one outstanding bus read, holds the fetched word until decode takes it.
// Build option IF_ADEL_CHECK_EN: misaligned PCs skip the bus and are reported via adel_o.
//
// state       | meaning
// ------------+-------------------------------------------------------------
// S_IDLE      | latch pc_i and raise the bus request
// S_WAIT_ADDR | request pending, waiting for inst_addr_ok
// S_WAIT_DATA | address accepted, waiting for inst_data_ok
// S_HOLD      | instruction valid, held until decode accepts it
// S_CANCEL    | flushed transaction, drain its data and drop it
module inst_fetch
    import inst_fetch_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc_i,
    input  logic              flush,
    input  logic              stall_i,
    inst_fetch_if.master      bus,
    output logic              inst_valid_o,
    output logic [DATA_W-1:0] inst_o,
    output logic [ADDR_W-1:0] inst_pc_o,
    output logic              adel_o,
    output logic              stall_req_o
);

    fetch_state_t      state, state_nx;
    logic              req_q, req_nx;
    logic [ADDR_W-1:0] addr_q, addr_nx;
    logic [ADDR_W-1:0] req_addr, req_addr_nx;
    logic              valid_q, valid_nx;
    logic [DATA_W-1:0] inst_q, inst_nx;
    logic [ADDR_W-1:0] pc_q, pc_nx;
    logic              flush_pend, flush_pend_nx;
`ifdef IF_ADEL_CHECK_EN
    logic              adel_q, adel_nx;
`endif

    always_comb begin
        state_nx      = state;
        req_nx        = req_q;
        addr_nx       = addr_q;
        req_addr_nx   = req_addr;
        valid_nx      = valid_q;
        inst_nx       = inst_q;
        pc_nx         = pc_q;
        flush_pend_nx = flush_pend;
`ifdef IF_ADEL_CHECK_EN
        adel_nx       = adel_q;
`endif
        case (state)
            S_IDLE: begin
                // pc_i is stale during a flush; wait one cycle for the new PC
                if (!flush) begin
                    req_addr_nx = pc_i;
`ifdef IF_ADEL_CHECK_EN
                    if (pc_i[1:0] != 2'b00) begin
                        valid_nx = 1'b1;
                        inst_nx  = INST_NOP;
                        pc_nx    = pc_i;
                        adel_nx  = 1'b1;
                        state_nx = S_HOLD;
                    end else
`endif
                    begin
                        req_nx   = 1'b1;
                        addr_nx  = {pc_i[ADDR_W-1:2], 2'b00};
                        state_nx = S_WAIT_ADDR;
                    end
                end
            end
            S_WAIT_ADDR: begin
                if (bus.inst_addr_ok) begin
                    req_nx        = 1'b0;
                    flush_pend_nx = 1'b0;
                    state_nx      = (flush || flush_pend) ? S_CANCEL : S_WAIT_DATA;
                end else if (flush) begin
                    flush_pend_nx = 1'b1;
                end
            end
            S_WAIT_DATA: begin
                if (bus.inst_data_ok) begin
                    if (!flush) begin
                        valid_nx = 1'b1;
                        inst_nx  = bus.inst_rdata;
                        pc_nx    = req_addr;
`ifdef IF_ADEL_CHECK_EN
                        adel_nx  = 1'b0;
`endif
                        state_nx = S_HOLD;
                    end else begin
                        state_nx = S_IDLE;
                    end
                end else if (flush) begin
                    state_nx = S_CANCEL;
                end
            end
            S_CANCEL: begin
                if (bus.inst_data_ok) state_nx = S_IDLE;
            end
            S_HOLD: begin
                if (flush || !stall_i) begin
                    valid_nx = 1'b0;
                    state_nx = S_IDLE;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            req_q      <= 1'b0;
            addr_q     <= '0;
            req_addr   <= '0;
            valid_q    <= 1'b0;
            inst_q     <= '0;
            pc_q       <= '0;
            flush_pend <= 1'b0;
`ifdef IF_ADEL_CHECK_EN
            adel_q     <= 1'b0;
`endif
        end else begin
            state      <= state_nx;
            req_q      <= req_nx;
            addr_q     <= addr_nx;
            req_addr   <= req_addr_nx;
            valid_q    <= valid_nx;
            inst_q     <= inst_nx;
            pc_q       <= pc_nx;
            flush_pend <= flush_pend_nx;
`ifdef IF_ADEL_CHECK_EN
            adel_q     <= adel_nx;
`endif
        end
    end

    assign bus.inst_req  = req_q;
    assign bus.inst_addr = addr_q;
    assign inst_valid_o  = valid_q;
    assign inst_o        = inst_q;
    assign inst_pc_o     = pc_q;
`ifdef IF_ADEL_CHECK_EN
    assign adel_o        = adel_q;
`else
    assign adel_o        = 1'b0;
`endif

    // The PC register advances only on the cycle decode consumes the held word
    assign stall_req_o = !(state == S_HOLD && !stall_i && !flush);

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: directed scenarios plus a randomized run
// against a transaction-level model of the fetch stage, PC register and bus.
module tb_inst_fetch;
    import inst_fetch_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_i;
    logic        flush;
    logic        stall_i;
    logic        inst_valid_o;
    logic [31:0] inst_o;
    logic [31:0] inst_pc_o;
    logic        adel_o;
    logic        stall_req_o;

    inst_fetch_if bus();

    inst_fetch dut (
        .clk          (clk),
        .rst          (rst),
        .pc_i         (pc_i),
        .flush        (flush),
        .stall_i      (stall_i),
        .bus          (bus),
        .inst_valid_o (inst_valid_o),
        .inst_o       (inst_o),
        .inst_pc_o    (inst_pc_o),
        .adel_o       (adel_o),
        .stall_req_o  (stall_req_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int delivered = 0;

    // Model: PC register, transaction flags and the held instruction
    logic [31:0] pc_reg;
    bit          m_req, m_wait, m_doom, m_valid, m_adel;
    logic [31:0] m_addr, m_req_pc, m_inst, m_pc;

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%b expected=%b", name, act, exp);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic model_clear();
        m_req = 0; m_wait = 0; m_doom = 0; m_valid = 0; m_adel = 0;
        m_addr = '0; m_req_pc = '0; m_inst = '0; m_pc = '0;
    endtask

    task automatic do_reset(input logic [31:0] start_pc);
        rst = 1'b1; flush = 1'b0; stall_i = 1'b0;
        bus.inst_addr_ok = 1'b0; bus.inst_data_ok = 1'b0; bus.inst_rdata = '0;
        pc_i = start_pc;
        repeat (2) @(posedge clk);
        #1;
        chk1 ("rst_req",   bus.inst_req, 1'b0);
        chk32("rst_addr",  bus.inst_addr, 32'h0);
        chk1 ("rst_valid", inst_valid_o, 1'b0);
        chk32("rst_inst",  inst_o, 32'h0);
        chk32("rst_pc",    inst_pc_o, 32'h0);
        chk1 ("rst_adel",  adel_o, 1'b0);
        model_clear();
        pc_reg = start_pc;
        pc_i   = start_pc;
        rst    = 1'b0;
    endtask

    // One clock cycle: apply inputs, check the combinational stall, advance
    // model and PC register, then check the registered outputs.
    task automatic step(input bit f, input bit s, input bit aok, input bit dok,
                        input logic [31:0] rd, input logic [31:0] ftgt);
        bit exp_sr;
        flush = f; stall_i = s;
        bus.inst_addr_ok = aok; bus.inst_data_ok = dok; bus.inst_rdata = rd;
        #1;
        exp_sr = !(m_valid && !s && !f);
        chk1("stall_req", stall_req_o, exp_sr);

        if (m_valid) begin
            if (f || !s) m_valid = 0;
        end else if (m_req) begin
            m_doom = m_doom | f;
            if (aok) begin m_req = 0; m_wait = 1; end
        end else if (m_wait) begin
            if (dok) begin
                m_wait = 0;
                if (!(m_doom || f)) begin
                    m_valid = 1; m_inst = rd; m_pc = m_req_pc; m_adel = 0;
                    delivered++;
                end
                m_doom = 0;
            end else begin
                m_doom = m_doom | f;
            end
        end else if (!f) begin
            m_req_pc = pc_i;
`ifdef IF_ADEL_CHECK_EN
            if (pc_i[1:0] != 2'b00) begin
                m_valid = 1; m_inst = 32'h0; m_pc = pc_i; m_adel = 1;
            end else
`endif
            begin
                m_req = 1; m_addr = pc_i & 32'hFFFF_FFFC;
            end
        end

        @(posedge clk);
        #1;
        if (f) pc_reg = ftgt;
        else if (!exp_sr) pc_reg = pc_reg + 32'd4;
        pc_i = pc_reg;

        chk1("inst_req", bus.inst_req, m_req);
        if (m_req) chk32("inst_addr", bus.inst_addr, m_addr);
        chk1("inst_valid", inst_valid_o, m_valid);
        if (m_valid) begin
            chk32("inst_o", inst_o, m_inst);
            chk32("inst_pc_o", inst_pc_o, m_pc);
            chk1("adel_o", adel_o, m_adel);
        end
    endtask

    initial begin
        // Minimum-latency fetch, then one PC advance
        do_reset(32'hBFC0_0000);
        step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        chk1 ("c1_req", bus.inst_req, 1'b1);
        chk32("c1_addr", bus.inst_addr, 32'hBFC0_0000);
        step(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
        chk1 ("c2_req", bus.inst_req, 1'b0);
        chk1 ("c2_valid", inst_valid_o, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 32'h2401_0001, 32'h0);
        chk1 ("c3_valid", inst_valid_o, 1'b1);
        chk32("c3_inst", inst_o, 32'h2401_0001);
        chk32("c3_pc", inst_pc_o, 32'hBFC0_0000);
        flush = 1'b0; stall_i = 1'b0; #1;
        chk1 ("c3_stall_req", stall_req_o, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        chk1 ("c4_valid", inst_valid_o, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        chk32("c5_next_addr", bus.inst_addr, 32'hBFC0_0004);

        // Delayed address acceptance, then a 5-cycle decode stall
        do_reset(32'hBFC0_0000);
        step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        for (int i = 0; i < 4; i++) begin
            chk1 ("wa_req", bus.inst_req, 1'b1);
            chk32("wa_addr", bus.inst_addr, 32'hBFC0_0000);
            step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        end
        step(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
        chk1 ("wa_accepted", bus.inst_req, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 32'h1111_2222, 32'h0);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
            chk1 ("hold_valid", inst_valid_o, 1'b1);
            chk32("hold_inst", inst_o, 32'h1111_2222);
            chk32("hold_pc", inst_pc_o, 32'hBFC0_0000);
        end
        step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        chk1 ("release_valid", inst_valid_o, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        chk32("release_addr", bus.inst_addr, 32'hBFC0_0004);

        // Flush in WAIT_DATA, data arrives two cycles later
        do_reset(32'hBFC0_0000);
        step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'hBFC0_0380);
        chk1 ("cancel_v0", inst_valid_o, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        chk1 ("cancel_v1", inst_valid_o, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF, 32'h0);
        chk1 ("cancel_v2", inst_valid_o, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        chk1 ("cancel_v3", inst_valid_o, 1'b0);
        chk1 ("cancel_req", bus.inst_req, 1'b1);
        chk32("cancel_addr", bus.inst_addr, 32'hBFC0_0380);

        // Flush coincident with data_ok
        do_reset(32'hBFC0_0000);
        step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
        step(1'b1, 1'b0, 1'b0, 1'b1, 32'hCAFE_0001, 32'hBFC0_0380);
        chk1 ("coinc_valid", inst_valid_o, 1'b0);
        chk1 ("coinc_req", bus.inst_req, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        chk1 ("coinc_idle_req", bus.inst_req, 1'b1);
        chk32("coinc_idle_addr", bus.inst_addr, 32'hBFC0_0380);

        // Misaligned PC
        do_reset(32'hBFC0_0002);
        step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
`ifdef IF_ADEL_CHECK_EN
        chk1 ("adel_noreq", bus.inst_req, 1'b0);
        chk1 ("adel_valid", inst_valid_o, 1'b1);
        chk1 ("adel_flag", adel_o, 1'b1);
        chk32("adel_pc", inst_pc_o, 32'hBFC0_0002);
        chk32("adel_inst", inst_o, 32'h0);
`else
        chk1 ("mis_req", bus.inst_req, 1'b1);
        chk32("mis_addr", bus.inst_addr, 32'hBFC0_0000);
        step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 32'h0);
        step(1'b0, 1'b1, 1'b0, 1'b1, 32'h1234_5678, 32'h0);
        chk1 ("mis_valid", inst_valid_o, 1'b1);
        chk1 ("mis_adel", adel_o, 1'b0);
        chk32("mis_pc", inst_pc_o, 32'hBFC0_0002);
`endif

        // Randomized traffic with occasional mid-transaction resets
        do_reset(32'hBFC0_0000);
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 199) == 0) begin
                do_reset($urandom & 32'hFFFF_FFFC);
            end else begin
                bit f, s, aok, dok;
                f   = ($urandom_range(0, 99) < 8);
                s   = ($urandom_range(0, 1) == 1);
                aok = m_req  && ($urandom_range(0, 2) == 0);
                dok = m_wait && ($urandom_range(0, 2) == 0);
                step(f, s, aok, dok, $urandom, $urandom & 32'hFFFF_FFFC);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
